// File: rtl/pe_ctrl_seq.sv
// Sequenced PE controller: accepts one vector command, issues elements to the PE
// datapath, tracks result latency and pulses done once the pipeline has drained.
module pe_ctrl_seq #(
  parameter int NUM_MUX    = 10,
  parameter int SEL_W      = 2,
  parameter int NUM_ADDSUB = 2,
  parameter int CNT_W      = 8,
  parameter int PIPE_LAT   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_cmd_valid,
  output logic                       io_cmd_ready,
  input  logic [1:0]                 io_cmd_op_type,
  input  logic                       io_cmd_use_int,
  input  logic [CNT_W-1:0]           io_cmd_len,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  output logic [NUM_MUX*SEL_W-1:0]   io_m_sel,
  output logic [NUM_ADDSUB*2-1:0]    io_addsub_op,
  output logic                       io_int_mode,
  output logic                       io_out_valid,
  output logic                       io_busy,
  output logic                       io_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MAC} op_t;

  state_t             state_q, state_d;
  op_t                op_q;
  logic               use_int_q;
  logic               first_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [PIPE_LAT-1:0] lat_q, lat_d;

  logic               accept, issue, last_issue, tag;
  logic [SEL_W-1:0]   sel;
  logic [1:0]         add_op;

  // Outputs are forced low while reset is held so nothing leaks mid-abort.
  assign io_cmd_ready = (state_q == S_IDLE)  & ~reset;
  assign io_in_ready  = (state_q == S_RUN)   & ~reset;
  assign io_done      = (state_q == S_DONE)  & ~reset;
  assign io_busy      = (state_q != S_IDLE)  & ~reset;
  assign io_out_valid = lat_q[PIPE_LAT-1]    & ~reset;
  assign io_int_mode  = io_busy & use_int_q;

  assign accept     = io_cmd_valid & io_cmd_ready;
  assign issue      = io_in_valid & io_in_ready;
  assign last_issue = issue & (remaining_q == CNT_W'(1));
  // MAC produces one accumulated result, so only its final element is tagged.
  assign tag        = issue & ((op_q != OP_MAC) | last_issue);

  always_comb begin
    lat_d[0] = tag;
    for (int i = 1; i < PIPE_LAT; i++) lat_d[i] = lat_q[i-1];
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    state_d = state_q;
    sel     = '0;
    add_op  = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (io_cmd_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (!reset) begin
          case (op_q)
            OP_SUB:  add_op = 2'd1;
            OP_MUL:  sel = SEL_W'(1);
            OP_MAC:  sel = first_q ? SEL_W'(1) : SEL_W'(2);
            default: sel = '0;
          endcase
        end
        if (last_issue) state_d = S_DRAIN;
      end
      // Leave DRAIN as the final tagged beat exits, so done follows it by one cycle.
      S_DRAIN: begin
        if (lat_d == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign io_m_sel     = {NUM_MUX{sel}};
  assign io_addsub_op = {NUM_ADDSUB{add_op}};

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the latency shift register is cleared on reset, otherwise an
      // aborted element could still surface as out_valid after reset drops.
      state_q     <= S_IDLE;
      lat_q       <= '0;
      remaining_q <= '0;
      op_q        <= OP_ADD;
      use_int_q   <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (accept) begin
        op_q        <= op_t'(io_cmd_op_type);
        use_int_q   <= io_cmd_use_int;
        remaining_q <= io_cmd_len;
        first_q     <= 1'b1;
      end else if (issue) begin
        if (remaining_q != '0) remaining_q <= remaining_q - CNT_W'(1);
        first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Directed bench for pe_ctrl_seq: per-cycle output traces compared against
// hand-computed bit masks (bit i = cycle i of the scenario).
module tb_pe_ctrl_seq;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_use_int;
  logic [7:0]  cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] m_sel;
  logic [3:0]  addsub_op;
  logic        int_mode;
  logic        out_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] cap_cmd_ready, cap_in_ready, cap_out_valid, cap_done, cap_busy, cap_int;
  logic [19:0] cap_sel    [0:31];
  logic [3:0]  cap_addsub [0:31];

  pe_ctrl_seq dut (
    .clock          (clock),
    .reset          (reset),
    .io_cmd_valid   (cmd_valid),
    .io_cmd_ready   (cmd_ready),
    .io_cmd_op_type (cmd_op),
    .io_cmd_use_int (cmd_use_int),
    .io_cmd_len     (cmd_len),
    .io_in_valid    (in_valid),
    .io_in_ready    (in_ready),
    .io_m_sel       (m_sel),
    .io_addsub_op   (addsub_op),
    .io_int_mode    (int_mode),
    .io_out_valid   (out_valid),
    .io_busy        (busy),
    .io_done        (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drives per-cycle patterns starting at posedge+1 and records outputs mid-cycle.
  task automatic run_cycles(input int n, input logic [31:0] iv, input logic [31:0] cv,
                            input logic [31:0] rp);
    cap_cmd_ready = '0; cap_in_ready = '0; cap_out_valid = '0;
    cap_done = '0; cap_busy = '0; cap_int = '0;
    for (int i = 0; i < 32; i++) begin
      cap_sel[i] = '0;
      cap_addsub[i] = '0;
    end
    for (int i = 0; i < n; i++) begin
      in_valid  = iv[i];
      cmd_valid = cv[i];
      reset     = rp[i];
      #1;
      cap_cmd_ready[i] = cmd_ready;
      cap_in_ready[i]  = in_ready;
      cap_out_valid[i] = out_valid;
      cap_done[i]      = done;
      cap_busy[i]      = busy;
      cap_int[i]       = int_mode;
      cap_sel[i]       = m_sel;
      cap_addsub[i]    = addsub_op;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    cmd_op = 2'd0; cmd_use_int = 1'b1; cmd_len = 8'd4;
    // Reset for cycles 0-1 with a command offered that must be ignored.
    run_cycles(4, 32'h0, 32'h3, 32'h3);
    checks++; if (cap_cmd_ready !== 32'hC) begin failures++; $display("FAIL reset_cmd_ready: got %h expected %h", cap_cmd_ready, 32'hC); end
    checks++; if (cap_busy !== 32'h0) begin failures++; $display("FAIL reset_busy: got %h expected %h", cap_busy, 32'h0); end
    checks++; if ((cap_in_ready | cap_out_valid | cap_done | cap_int) !== 32'h0) begin failures++; $display("FAIL reset_outputs: got %h expected %h", cap_in_ready | cap_out_valid | cap_done | cap_int, 32'h0); end
    checks++; if ((cap_sel[0] | cap_sel[1]) !== 20'h0) begin failures++; $display("FAIL reset_sel: got %h expected %h", cap_sel[0] | cap_sel[1], 20'h0); end
  endtask

  task automatic test_add;
    cmd_op = 2'd0; cmd_use_int = 1'b1; cmd_len = 8'd4;
    run_cycles(11, 32'h7FF, 32'h1, 32'h0);
    checks++; if (cap_in_ready !== 32'h1E) begin failures++; $display("FAIL add_in_ready: got %h expected %h", cap_in_ready, 32'h1E); end
    checks++; if (cap_out_valid !== 32'hF0) begin failures++; $display("FAIL add_out_valid: got %h expected %h", cap_out_valid, 32'hF0); end
    checks++; if (cap_done !== 32'h100) begin failures++; $display("FAIL add_done: got %h expected %h", cap_done, 32'h100); end
    checks++; if (cap_cmd_ready !== 32'h601) begin failures++; $display("FAIL add_cmd_ready: got %h expected %h", cap_cmd_ready, 32'h601); end
    checks++; if (cap_busy !== 32'h1FE) begin failures++; $display("FAIL add_busy: got %h expected %h", cap_busy, 32'h1FE); end
    checks++; if (cap_int !== 32'h1FE) begin failures++; $display("FAIL add_int_mode: got %h expected %h", cap_int, 32'h1FE); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cap_sel[i] !== 20'h0 || cap_addsub[i] !== 4'h0) begin
        failures++; $display("FAIL add_sel_c%0d: got sel=%h op=%h expected sel=0 op=0", i, cap_sel[i], cap_addsub[i]);
      end
    end
  endtask

  task automatic test_mac;
    logic [19:0] exp_sel;
    cmd_op = 2'd3; cmd_use_int = 1'b0; cmd_len = 8'd3;
    run_cycles(9, 32'h1FF, 32'h1, 32'h0);
    checks++; if (cap_in_ready !== 32'hE) begin failures++; $display("FAIL mac_in_ready: got %h expected %h", cap_in_ready, 32'hE); end
    checks++; if (cap_out_valid !== 32'h40) begin failures++; $display("FAIL mac_out_valid: got %h expected %h", cap_out_valid, 32'h40); end
    checks++; if (cap_done !== 32'h80) begin failures++; $display("FAIL mac_done: got %h expected %h", cap_done, 32'h80); end
    checks++; if (cap_int !== 32'h0) begin failures++; $display("FAIL mac_int_mode: got %h expected %h", cap_int, 32'h0); end
    for (int i = 0; i < 9; i++) begin
      exp_sel = (i == 1) ? 20'h55555 : ((i == 2 || i == 3) ? 20'hAAAAA : 20'h0);
      checks++;
      if (cap_sel[i] !== exp_sel) begin
        failures++; $display("FAIL mac_sel_c%0d: got %h expected %h", i, cap_sel[i], exp_sel);
      end
    end
  endtask

  task automatic test_sub_gaps;
    logic [3:0] exp_op;
    cmd_op = 2'd1; cmd_use_int = 1'b1; cmd_len = 8'd2;
    run_cycles(9, 32'hA, 32'h1, 32'h0);
    checks++; if (cap_in_ready !== 32'hE) begin failures++; $display("FAIL sub_in_ready: got %h expected %h", cap_in_ready, 32'hE); end
    checks++; if (cap_out_valid !== 32'h50) begin failures++; $display("FAIL sub_out_valid: got %h expected %h", cap_out_valid, 32'h50); end
    checks++; if (cap_done !== 32'h80) begin failures++; $display("FAIL sub_done: got %h expected %h", cap_done, 32'h80); end
    for (int i = 0; i < 9; i++) begin
      exp_op = (i >= 1 && i <= 3) ? 4'h5 : 4'h0;
      checks++;
      if (cap_addsub[i] !== exp_op) begin
        failures++; $display("FAIL sub_addsub_c%0d: got %h expected %h", i, cap_addsub[i], exp_op);
      end
    end
  endtask

  task automatic test_zero_len;
    cmd_op = 2'd2; cmd_use_int = 1'b0; cmd_len = 8'd0;
    run_cycles(4, 32'hF, 32'h1, 32'h0);
    checks++; if (cap_in_ready !== 32'h0) begin failures++; $display("FAIL zero_in_ready: got %h expected %h", cap_in_ready, 32'h0); end
    checks++; if (cap_out_valid !== 32'h0) begin failures++; $display("FAIL zero_out_valid: got %h expected %h", cap_out_valid, 32'h0); end
    checks++; if (cap_done !== 32'h2) begin failures++; $display("FAIL zero_done: got %h expected %h", cap_done, 32'h2); end
    checks++; if (cap_cmd_ready !== 32'hD) begin failures++; $display("FAIL zero_cmd_ready: got %h expected %h", cap_cmd_ready, 32'hD); end
    checks++; if ((cap_sel[0] | cap_sel[1] | cap_sel[2]) !== 20'h0) begin failures++; $display("FAIL zero_sel: got %h expected %h", cap_sel[0] | cap_sel[1] | cap_sel[2], 20'h0); end
  endtask

  task automatic test_reset_mid_run;
    // len=5 ADD; reset during cycles 3-4 after 2 issues; same command re-offered at cycle 5.
    cmd_op = 2'd0; cmd_use_int = 1'b1; cmd_len = 8'd5;
    run_cycles(16, 32'hFFFF, 32'h21, 32'h18);
    checks++; if (cap_in_ready !== 32'h7C6) begin failures++; $display("FAIL abort_in_ready: got %h expected %h", cap_in_ready, 32'h7C6); end
    checks++; if (cap_out_valid !== 32'h3E00) begin failures++; $display("FAIL abort_out_valid: got %h expected %h", cap_out_valid, 32'h3E00); end
    checks++; if (cap_done !== 32'h4000) begin failures++; $display("FAIL abort_done: got %h expected %h", cap_done, 32'h4000); end
    checks++; if (cap_cmd_ready !== 32'h8021) begin failures++; $display("FAIL abort_cmd_ready: got %h expected %h", cap_cmd_ready, 32'h8021); end
    checks++; if (cap_busy !== 32'h7FC6) begin failures++; $display("FAIL abort_busy: got %h expected %h", cap_busy, 32'h7FC6); end
    checks++; if (cap_int !== 32'h7FC6) begin failures++; $display("FAIL abort_int_mode: got %h expected %h", cap_int, 32'h7FC6); end
    checks++; if (cap_sel[4] !== 20'h0 || cap_addsub[4] !== 4'h0) begin failures++; $display("FAIL abort_sel: got sel=%h op=%h expected sel=0 op=0", cap_sel[4], cap_addsub[4]); end
  endtask

  task automatic test_back_to_back;
    // cmd_valid held through RUN/DRAIN/DONE: second accept only the cycle after done.
    cmd_op = 2'd0; cmd_use_int = 1'b0; cmd_len = 8'd1;
    run_cycles(13, 32'h1FFF, 32'hFFF, 32'h0);
    checks++; if (cap_cmd_ready !== 32'h1041) begin failures++; $display("FAIL b2b_cmd_ready: got %h expected %h", cap_cmd_ready, 32'h1041); end
    checks++; if (cap_in_ready !== 32'h82) begin failures++; $display("FAIL b2b_in_ready: got %h expected %h", cap_in_ready, 32'h82); end
    checks++; if (cap_out_valid !== 32'h410) begin failures++; $display("FAIL b2b_out_valid: got %h expected %h", cap_out_valid, 32'h410); end
    checks++; if (cap_done !== 32'h820) begin failures++; $display("FAIL b2b_done: got %h expected %h", cap_done, 32'h820); end
    checks++; if (cap_busy !== 32'hFBE) begin failures++; $display("FAIL b2b_busy: got %h expected %h", cap_busy, 32'hFBE); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0;
    cmd_op = 2'd0; cmd_use_int = 1'b0; cmd_len = 8'd0;
    @(posedge clock);
    #1;
    test_reset();
    test_add();
    test_mac();
    test_sub_gaps();
    test_zero_len();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
